// File: rtl/inst_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// FSM state encoding plus the calculator opcode field values.
// No logic lives here; the package is imported by the sequencer top.
package inst_seq_pkg;

  // Replay FSM states, in the order they are normally visited.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_LEN  = 3'd1,
    ST_CHK_LEN = 3'd2,
    ST_FETCH   = 3'd3,
    ST_GAP     = 3'd4,
    ST_ISSUE   = 3'd5,
    ST_HOLD    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Calculator opcode field (top two bits of an instruction word).
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

endpackage

// File: rtl/inst_seq_mem.sv
// Program image store: DEPTH x INST_W, one write port, one synchronous read port.
// Read latency 1 cycle (rd_data holds mem[rd_addr] sampled at the previous edge).
// No backpressure; contents are deliberately not reset.
module inst_seq_mem #(
  parameter int INST_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem [2**ADDR_W];

  // Single-cycle write and registered read every cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/inst_seq.sv
// Instruction sequencer: replays a stored program onto the instruction bus with gap/hold spacing.
// Per instruction: 1 fetch + GAP_CYC + issue (>=1) + HOLD_CYC cycles; done 3 cycles after start for empty/bad programs.
// inst_wd/inst_vld are held until inst_rdy; no timeout, only abort or rst ends a stall.
module inst_seq
  import inst_seq_pkg::*;
#(
  parameter int INST_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int GAP_CYC  = 150000,
  parameter int HOLD_CYC = 300000,
  parameter int CNT_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  output logic [INST_W-1:0] inst_wd,
  output logic              inst_vld,
  input  logic              inst_rdy,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam int DEPTH = 2**ADDR_W;
  // Counter load values: the state lasts (load + 1) cycles, exiting when the counter reads 0.
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYC  > 0) ? CNT_W'(GAP_CYC  - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] len_q, len_d;
  logic [INST_W-1:0] wd_q, wd_d;
  logic              len_err_q, len_err_d;
  logic [INST_W-1:0] rd_data;
  logic              last_inst;
  state_t            adv_state;
  logic [ADDR_W-1:0] adv_idx;

  // The RAM is addressed with the next index so that the word for a state is
  // already on rd_data while the FSM sits in it (count word in RD_LEN, instruction in FETCH).
  inst_seq_mem #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en && (state_q == ST_IDLE)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  // Where to go once an instruction's hold time has elapsed: next word, wrap, or finish.
  always_comb begin
    last_inst = (32'(idx_q) == 32'(len_q));
    adv_state = ST_FETCH;
    adv_idx   = idx_q + 1'b1;
    if (last_inst) begin
      if (loop_en) begin
        adv_idx = ADDR_W'(1);
      end else begin
        adv_state = ST_DONE;
        adv_idx   = idx_q;
      end
    end
  end

  // Next-state, index, counter and captured-data logic; abort overrides outside IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wd_d      = wd_q;
    len_err_d = len_err_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (start) begin
          state_d   = ST_RD_LEN;
          len_err_d = 1'b0;
        end
      end
      ST_RD_LEN: begin
        len_d   = rd_data;
        state_d = ST_CHK_LEN;
      end
      ST_CHK_LEN: begin
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else if (32'(len_q) > DEPTH - 1) begin
          len_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          idx_d   = ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        wd_d = rd_data;
        if (GAP_CYC == 0) begin
          state_d = ST_ISSUE;
        end else begin
          cnt_d   = GAP_LD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_ISSUE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ISSUE: begin
        if (inst_rdy) begin
          if (HOLD_CYC == 0) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end else begin
            cnt_d   = HOLD_LD;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wd_q      <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wd_q      <= wd_d;
      len_err_q <= len_err_d;
    end
  end

  assign inst_wd  = wd_q;
  assign inst_vld = (state_q == ST_ISSUE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign len_err  = len_err_q;
  assign cur_idx  = idx_q;

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: directed scenarios plus randomized programs and backpressure.
// Expected streams and cycle numbers come from the program image and per-instruction timing arithmetic.
// The DUT is driven 1 time unit after each rising edge and observed on the falling edge.
module tb_inst_seq;

  localparam int INST_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int GAP_CYC  = 2;
  localparam int HOLD_CYC = 3;
  localparam int CNT_W    = 8;
  localparam int DEPTH    = 2**ADDR_W;
  localparam int PER      = 1 + GAP_CYC + 1 + HOLD_CYC;

  logic              clk = 1'b0;
  logic              rst, wr_en, start, loop_en, abort, inst_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [INST_W-1:0] wr_data;
  logic [INST_W-1:0] inst_wd;
  logic              inst_vld, busy, done, len_err;
  logic [ADDR_W-1:0] cur_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] acc_q [$];
  int         acc_c [$];
  int         done_c [$];
  logic [7:0] img [DEPTH];

  inst_seq #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .GAP_CYC(GAP_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .loop_en(loop_en), .abort(abort),
    .inst_wd(inst_wd), .inst_vld(inst_vld), .inst_rdy(inst_rdy),
    .busy(busy), .done(done), .len_err(len_err), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted instruction and every done pulse with its cycle number.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_vld && inst_rdy) begin
        acc_q.push_back(inst_wd);
        acc_c.push_back(cyc);
      end
      if (done) done_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    acc_q.delete();
    acc_c.delete();
    done_c.delete();
  endtask

  task automatic write_word(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    tick(1);
    wr_en   = 1'b0;
  endtask

  // Program image: word 0 = count, then the instructions; mirrored into img.
  task automatic load_prog(input int n, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
    img[0] = 8'(n); img[1] = w1; img[2] = w2; img[3] = w3;
    for (int a = 0; a <= 3; a++) write_word(a, img[a]);
  endtask

  task automatic pulse_start(output int k);
    k = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_issue(input int idx, input int budget);
    int n = 0;
    while (!(inst_vld && cur_idx == ADDR_W'(idx)) && n < budget) begin
      tick(1);
      n++;
    end
    if (!inst_vld) check("issue_timeout", inst_vld, 1);
  endtask

  // Accepted stream must be the image's words 1..n in order, with a single done pulse.
  task automatic check_stream(input string tag, input int n);
    check({tag, "_count"}, acc_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++)
      check({tag, "_data"}, acc_q[i], img[i + 1]);
    check({tag, "_done_pulses"}, done_c.size(), 1);
  endtask

  initial begin
    int k;
    int n;
    logic stable;
    logic [7:0] held;
    logic prev_stall;
    logic [7:0] prev_wd;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; loop_en = 1'b0; abort = 1'b0; inst_rdy = 1'b1;
    tick(3);
    check("rst_inst_wd", inst_wd, 0);
    check("rst_vld", inst_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_cur_idx", cur_idx, 0);
    rst = 1'b0;
    tick(1);

    // Straight replay, no backpressure: fixed spacing and done timing.
    load_prog(3, 8'h05, 8'h16, 8'hC4);
    clear_log();
    pulse_start(k);
    wait_idle(200);
    check_stream("t1", 3);
    for (int i = 0; i < 3 && i < acc_c.size(); i++)
      check("t1_issue_cycle", acc_c[i], k + 4 + GAP_CYC + i * PER);
    if (done_c.size() > 0) check("t1_done_cycle", done_c[0], k + 3 + 3 * PER);
    tick(1);
    check("t1_busy_after", busy, 0);

    // Stall the second instruction for 10 cycles.
    clear_log();
    pulse_start(k);
    n = 0;
    while (cur_idx != ADDR_W'(2) && n < 100) begin tick(1); n++; end
    inst_rdy = 1'b0;
    wait_issue(2, 50);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(inst_vld && inst_wd == 8'h16)) stable = 1'b0;
      tick(1);
    end
    check("t2_stall_stable", stable, 1);
    check("t2_stall_wd", inst_wd, 8'h16);
    inst_rdy = 1'b1;
    wait_idle(200);
    check_stream("t2", 3);

    // Empty program and oversize count word.
    img[0] = 8'd0;
    write_word(0, 8'd0);
    clear_log();
    pulse_start(k);
    wait_idle(50);
    check("t3_zero_accepts", acc_q.size(), 0);
    if (done_c.size() > 0) check("t3_zero_done_cycle", done_c[0], k + 3);
    check("t3_zero_done_pulses", done_c.size(), 1);
    check("t3_zero_len_err", len_err, 0);
    write_word(0, 8'd16);
    clear_log();
    pulse_start(k);
    wait_idle(50);
    check("t3_big_accepts", acc_q.size(), 0);
    check("t3_big_done_pulses", done_c.size(), 1);
    if (done_c.size() > 0) check("t3_big_done_cycle", done_c[0], k + 3);
    check("t3_big_len_err", len_err, 1);
    tick(3);
    check("t3_len_err_sticky", len_err, 1);

    // Loop mode: drop loop_en after five accepts, run ends at the pass boundary.
    load_prog(2, 8'h01, 8'h02, 8'h00);
    clear_log();
    loop_en = 1'b1;
    pulse_start(k);
    check("t3_len_err_cleared", len_err, 0);
    n = 0;
    while (acc_q.size() < 5 && n < 200) begin tick(1); n++; end
    loop_en = 1'b0;
    wait_idle(200);
    check("t4_count", acc_q.size(), ((5 + 1) / 2) * 2);
    for (int i = 0; i < acc_q.size(); i++)
      check("t4_data", acc_q[i], img[1 + (i % 2)]);
    if (acc_c.size() > 2) check("t4_wrap_spacing", acc_c[2] - acc_c[1], PER);
    check("t4_done_pulses", done_c.size(), 1);

    // Abort mid-handshake on the second instruction, then a fresh run.
    load_prog(3, 8'h05, 8'h16, 8'hC4);
    clear_log();
    pulse_start(k);
    n = 0;
    while (cur_idx != ADDR_W'(2) && n < 100) begin tick(1); n++; end
    inst_rdy = 1'b0;
    wait_issue(2, 50);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_vld_after_abort", inst_vld, 0);
    check("t5_busy_after_abort", busy, 0);
    tick(5);
    check("t5_no_done", done_c.size(), 0);
    inst_rdy = 1'b1;
    clear_log();
    pulse_start(k);
    wait_idle(200);
    check_stream("t5_rerun", 3);

    // Randomized programs under random backpressure.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 6);
      img[0] = 8'(len);
      write_word(0, img[0]);
      for (int a = 1; a <= len; a++) begin
        img[a] = 8'($urandom);
        write_word(a, img[a]);
      end
      clear_log();
      pulse_start(k);
      prev_stall = 1'b0;
      prev_wd = '0;
      n = 0;
      while (busy && n < 600) begin
        if (prev_stall) begin
          check("rnd_hold_vld", inst_vld, 1);
          check("rnd_hold_wd", inst_wd, prev_wd);
        end
        inst_rdy = 1'($urandom_range(0, 1));
        prev_stall = inst_vld && !inst_rdy;
        prev_wd = inst_wd;
        tick(1);
        n++;
      end
      if (busy) check("rnd_timeout", busy, 0);
      inst_rdy = 1'b1;
      check_stream("rnd", len);
    end

    // Writes and start while busy are ignored.
    load_prog(3, 8'h05, 8'h16, 8'hC4);
    clear_log();
    pulse_start(k);
    tick(4);
    write_word(2, 8'hFF);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(200);
    check_stream("t6_busy_wr", 3);
    tick(2);
    check("t6_no_restart", busy, 0);
    clear_log();
    pulse_start(k);
    wait_idle(200);
    check_stream("t6_rerun", 3);

    // Reset in the middle of the gap.
    clear_log();
    pulse_start(k);
    n = 0;
    while (cyc < k + 4 + 1 && n < 20) begin tick(1); n++; end
    held = inst_wd;
    rst = 1'b1;
    tick(1);
    check("t6_rst_inst_wd", inst_wd, 0);
    check("t6_rst_vld", inst_vld, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_cur_idx", cur_idx, 0);
    check("t6_rst_len_err", len_err, 0);
    rst = 1'b0;
    tick(2);
    check("t6_idle_after_rst", busy, 0);
    if (held == 8'h00) tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
